ascon_decrypt_core: RTL and testbench

- ASCON-128 authenticated decryption core: the receive-side counterpart of the encryption datapath.
- Runs initialization, associated-data absorption, streaming ciphertext decryption, finalization and constant-time tag comparison.
- Performs one permutation round per cycle under an internal FSM and round counter; no external round sequencing.
- Sits between the ciphertext source and the plaintext consumer; the plaintext must be discarded unless tag_ok_o=1 at done_o.

---
 rtl/ascon_decrypt_core_pkg.sv | 59 +++++
 rtl/ascon_decrypt_core_round.sv | 51 +++++
 rtl/ascon_decrypt_core.sv | 198 +++++++++++++++++++
 tb/tb_ascon_decrypt_core.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_decrypt_core_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : ascon_decrypt_core_pkg
// Description : Shared ASCON definitions: 320-bit state type, IV, round-count
//               defaults, FSM state encoding, round-constant and byte-lane
//               helper functions used by the decryption core.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
package ascon_decrypt_core_pkg;

    // Five 64-bit words, x0 occupies the most significant bits.
    typedef struct packed {
        logic [63:0] x0;
        logic [63:0] x1;
        logic [63:0] x2;
        logic [63:0] x3;
        logic [63:0] x4;
    } type_state;

    localparam logic [63:0] c_iv       = 64'h80400c0600000000;
    localparam int unsigned c_rounds_a = 12;
    localparam int unsigned c_rounds_b = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INIT   = 3'd1,
        ST_ADAT   = 3'd2,
        ST_WAIT_C = 3'd3,
        ST_PROC   = 3'd4,
        ST_FINAL  = 3'd5,
        ST_CHECK  = 3'd6
    } type_fsm;

    // Round constant for round index idx (0..11 in the 12-round schedule).
    function automatic logic [7:0] round_const(input logic [3:0] idx);
        return {4'hF - idx, idx};
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Ones over the top n bytes (byte 0 = bits 63:56).
    function automatic logic [63:0] byte_mask(input logic [2:0] n);
        logic [63:0] m;
        m = '0;
        for (int b = 0; b < 8; b++) begin
            if (b < int'(n)) m[63 - 8*b -: 8] = 8'hFF;
        end
        return m;
    endfunction

    // 0x80 padding byte placed in byte lane n.
    function automatic logic [63:0] pad_byte(input logic [2:0] n);
        return 64'h80 << (8 * (3'd7 - n));
    endfunction

endpackage
`default_nettype wire

// File: rtl/ascon_decrypt_core_round.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : ascon_round
// Description : One combinational ASCON permutation round: constant addition
//               into x2, bit-sliced 5-bit S-box, linear diffusion per word.
// Ports       : i_state - state before the round
//               i_rnd   - 4-bit round index selecting the constant
//               o_state - state after the round
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module ascon_round
    import ascon_decrypt_core_pkg::*;
(
    input  type_state   i_state,
    input  logic [3:0]  i_rnd,
    output type_state   o_state
);

    logic [63:0] w_p0, w_p1, w_p2, w_p3, w_p4;
    logic [63:0] w_q0, w_q1, w_q2, w_q3, w_q4;
    logic [63:0] w_r0, w_r1, w_r2, w_r3, w_r4;

    // Constant addition folded into the S-box input XOR stage.
    assign w_p0 = i_state.x0 ^ i_state.x4;
    assign w_p1 = i_state.x1;
    assign w_p2 = i_state.x2 ^ {56'd0, round_const(i_rnd)} ^ i_state.x1;
    assign w_p3 = i_state.x3;
    assign w_p4 = i_state.x4 ^ i_state.x3;

    // Chi-like nonlinear core.
    assign w_q0 = w_p0 ^ (~w_p1 & w_p2);
    assign w_q1 = w_p1 ^ (~w_p2 & w_p3);
    assign w_q2 = w_p2 ^ (~w_p3 & w_p4);
    assign w_q3 = w_p3 ^ (~w_p4 & w_p0);
    assign w_q4 = w_p4 ^ (~w_p0 & w_p1);

    // Output mixing of the S-box.
    assign w_r0 = w_q0 ^ w_q4;
    assign w_r1 = w_q1 ^ w_q0;
    assign w_r2 = ~w_q2;
    assign w_r3 = w_q3 ^ w_q2;
    assign w_r4 = w_q4;

    assign o_state.x0 = w_r0 ^ rotr(w_r0, 19) ^ rotr(w_r0, 28);
    assign o_state.x1 = w_r1 ^ rotr(w_r1, 61) ^ rotr(w_r1, 39);
    assign o_state.x2 = w_r2 ^ rotr(w_r2,  1) ^ rotr(w_r2,  6);
    assign o_state.x3 = w_r3 ^ rotr(w_r3, 10) ^ rotr(w_r3, 17);
    assign o_state.x4 = w_r4 ^ rotr(w_r4,  7) ^ rotr(w_r4, 41);

endmodule
`default_nettype wire

// File: rtl/ascon_decrypt_core.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : ascon_decrypt_core
// Description : ASCON-128 authenticated decryption, one permutation round per
//               cycle. Init, single AD block, streaming ciphertext, final
//               permutation and constant-time tag comparison.
// Ports       : clock_i/reset_i        - clock, async active-high reset
//               start_i                - begin a message (IDLE only)
//               key_i/nonce_i/ad_i     - key (held), nonce and AD (sampled)
//               tag_i                  - expected tag (held until done_o)
//               cipher_*               - ciphertext stream, valid/ready
//               plain_o/plain_valid_o  - plaintext, one pulse per block
//               busy_o/done_o/tag_ok_o - status; tag_ok_o valid at done_o
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module ascon_decrypt_core
    import ascon_decrypt_core_pkg::*;
#(
    parameter int unsigned ROUNDS_A = c_rounds_a,
    parameter int unsigned ROUNDS_B = c_rounds_b
)(
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic [127:0] key_i,
    input  logic [127:0] nonce_i,
    input  logic [63:0]  ad_i,
    input  logic [127:0] tag_i,
    input  logic [63:0]  cipher_i,
    input  logic         cipher_valid_i,
    input  logic         cipher_last_i,
    input  logic [2:0]   cipher_nbytes_i,
    output logic         cipher_ready_o,
    output logic [63:0]  plain_o,
    output logic         plain_valid_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         tag_ok_o
);

    localparam logic [3:0] c_last_a = 4'(ROUNDS_A - 1);
    localparam logic [3:0] c_last_b = 4'(ROUNDS_B - 1);
    // Data-block rounds use the tail of the 12-entry constant schedule.
    localparam logic [3:0] c_off_b  = 4'(12 - ROUNDS_B);

    type_fsm     r_fsm, w_fsm_next;
    type_state   r_s, w_s_next;
    type_state   w_round_out;
    logic [3:0]  r_rcnt, w_rcnt_next;
    logic [3:0]  w_rnd_idx;
    logic [63:0] r_ad, w_ad_next;
    logic [63:0] r_plain, w_plain_next;
    logic        r_plain_valid, w_plain_valid_next;
    logic        r_done, w_done_next;
    logic        r_tag_ok, w_tag_ok_next;
    logic [63:0] w_mask;
    logic [63:0] w_pad;
    logic [127:0] w_tag_diff;

    assign w_rnd_idx = (r_fsm == ST_ADAT || r_fsm == ST_PROC) ? (r_rcnt + c_off_b) : r_rcnt;

    ascon_round u_round (
        .i_state (r_s),
        .i_rnd   (w_rnd_idx),
        .o_state (w_round_out)
    );

    assign w_mask = byte_mask(cipher_nbytes_i);
    assign w_pad  = pad_byte(cipher_nbytes_i);
    // Every bit of the difference is folded; no data-dependent early exit.
    assign w_tag_diff = {r_s.x3 ^ key_i[127:64], r_s.x4 ^ key_i[63:0]} ^ tag_i;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_fsm         <= ST_IDLE;
            r_s           <= '0;
            r_rcnt        <= '0;
            r_ad          <= '0;
            r_plain       <= '0;
            r_plain_valid <= 1'b0;
            r_done        <= 1'b0;
            r_tag_ok      <= 1'b0;
        end else begin
            r_fsm         <= w_fsm_next;
            r_s           <= w_s_next;
            r_rcnt        <= w_rcnt_next;
            r_ad          <= w_ad_next;
            r_plain       <= w_plain_next;
            r_plain_valid <= w_plain_valid_next;
            r_done        <= w_done_next;
            r_tag_ok      <= w_tag_ok_next;
        end
    end

    always_comb begin
        w_fsm_next         = r_fsm;
        w_s_next           = r_s;
        w_rcnt_next        = r_rcnt;
        w_ad_next          = r_ad;
        w_plain_next       = r_plain;
        w_plain_valid_next = 1'b0;
        w_done_next        = 1'b0;
        w_tag_ok_next      = r_tag_ok;

        case (r_fsm)
            ST_IDLE: begin
                if (start_i) begin
                    w_s_next      = {c_iv, key_i, nonce_i};
                    w_rcnt_next   = '0;
                    w_ad_next     = ad_i;
                    w_tag_ok_next = 1'b0;
                    w_fsm_next    = ST_INIT;
                end
            end

            ST_INIT: begin
                w_s_next    = w_round_out;
                w_rcnt_next = r_rcnt + 4'd1;
                if (r_rcnt == c_last_a) begin
                    // Key XOR after init, then absorb the single AD block.
                    w_s_next.x3 = w_round_out.x3 ^ key_i[127:64];
                    w_s_next.x4 = w_round_out.x4 ^ key_i[63:0];
                    w_s_next.x0 = w_round_out.x0 ^ r_ad;
                    w_rcnt_next = '0;
                    w_fsm_next  = ST_ADAT;
                end
            end

            ST_ADAT: begin
                w_s_next    = w_round_out;
                w_rcnt_next = r_rcnt + 4'd1;
                if (r_rcnt == c_last_b) begin
                    // Domain separation between AD and message.
                    w_s_next.x4 = w_round_out.x4 ^ 64'd1;
                    w_rcnt_next = '0;
                    w_fsm_next  = ST_WAIT_C;
                end
            end

            ST_WAIT_C: begin
                if (cipher_valid_i) begin
                    w_plain_valid_next = 1'b1;
                    w_rcnt_next        = '0;
                    if (!cipher_last_i) begin
                        w_plain_next = cipher_i ^ r_s.x0;
                        w_s_next.x0  = cipher_i;
                        w_fsm_next   = ST_PROC;
                    end else begin
                        // Partial block: ciphertext overwrites the used lanes,
                        // the rest of x0 stays and gets the pad byte.
                        w_plain_next = (cipher_i ^ r_s.x0) & w_mask;
                        w_s_next.x0  = ((cipher_i & w_mask) | (r_s.x0 & ~w_mask)) ^ w_pad;
                        w_s_next.x1  = r_s.x1 ^ key_i[127:64];
                        w_s_next.x2  = r_s.x2 ^ key_i[63:0];
                        w_fsm_next   = ST_FINAL;
                    end
                end
            end

            ST_PROC: begin
                w_s_next    = w_round_out;
                w_rcnt_next = r_rcnt + 4'd1;
                if (r_rcnt == c_last_b) begin
                    w_rcnt_next = '0;
                    w_fsm_next  = ST_WAIT_C;
                end
            end

            ST_FINAL: begin
                w_s_next    = w_round_out;
                w_rcnt_next = r_rcnt + 4'd1;
                if (r_rcnt == c_last_a) begin
                    w_rcnt_next = '0;
                    w_fsm_next  = ST_CHECK;
                end
            end

            ST_CHECK: begin
                w_done_next   = 1'b1;
                w_tag_ok_next = ~|w_tag_diff;
                w_fsm_next    = ST_IDLE;
            end

            default: begin
                w_fsm_next = ST_IDLE;
            end
        endcase
    end

    assign cipher_ready_o = (r_fsm == ST_WAIT_C);
    assign busy_o         = (r_fsm != ST_IDLE);
    assign plain_o        = r_plain;
    assign plain_valid_o  = r_plain_valid;
    assign done_o         = r_done;
    assign tag_ok_o       = r_tag_ok;

endmodule
`default_nettype wire

// File: tb/tb_ascon_decrypt_core.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_ascon_decrypt_core
// Description : Self-checking bench for ascon_decrypt_core. An ASCON-128
//               encryption model (S-box by lookup table) produces ciphertext
//               and tag; the DUT must return the original plaintext and the
//               right tag verdict, with the stated latencies.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_ascon_decrypt_core;

    logic         clk = 1'b0;
    logic         reset_i;
    logic         start_i;
    logic [127:0] key_i, nonce_i, tag_i;
    logic [63:0]  ad_i, cipher_i;
    logic         cipher_valid_i, cipher_last_i;
    logic [2:0]   cipher_nbytes_i;
    logic         cipher_ready_o, plain_valid_o, busy_o, done_o, tag_ok_o;
    logic [63:0]  plain_o;

    int vectors = 0;
    int miscompares = 0;

    ascon_decrypt_core dut (
        .clock_i         (clk),
        .reset_i         (reset_i),
        .start_i         (start_i),
        .key_i           (key_i),
        .nonce_i         (nonce_i),
        .ad_i            (ad_i),
        .tag_i           (tag_i),
        .cipher_i        (cipher_i),
        .cipher_valid_i  (cipher_valid_i),
        .cipher_last_i   (cipher_last_i),
        .cipher_nbytes_i (cipher_nbytes_i),
        .cipher_ready_o  (cipher_ready_o),
        .plain_o         (plain_o),
        .plain_valid_o   (plain_valid_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .tag_ok_o        (tag_ok_o)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [4:0] sbox_tbl [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

    logic [63:0]  ms [5];
    logic [7:0]   msg [$];
    logic [63:0]  ct [$];
    logic [63:0]  exp_pt [$];
    int           last_n;
    logic [127:0] exp_tag;

    function automatic logic [63:0] m_ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic void m_perm(input int nr);
        logic [4:0] col;
        for (int r = 12 - nr; r < 12; r++) begin
            ms[2] = ms[2] ^ {56'd0, 4'(15 - r), 4'(r)};
            for (int b = 0; b < 64; b++) begin
                col = sbox_tbl[{ms[0][b], ms[1][b], ms[2][b], ms[3][b], ms[4][b]}];
                {ms[0][b], ms[1][b], ms[2][b], ms[3][b], ms[4][b]} = col;
            end
            ms[0] = ms[0] ^ m_ror(ms[0], 19) ^ m_ror(ms[0], 28);
            ms[1] = ms[1] ^ m_ror(ms[1], 61) ^ m_ror(ms[1], 39);
            ms[2] = ms[2] ^ m_ror(ms[2],  1) ^ m_ror(ms[2],  6);
            ms[3] = ms[3] ^ m_ror(ms[3], 10) ^ m_ror(ms[3], 17);
            ms[4] = ms[4] ^ m_ror(ms[4],  7) ^ m_ror(ms[4], 41);
        end
    endfunction

    // ASCON-128 encryption of msg[] -> ct[], exp_pt[], exp_tag.
    function automatic void m_encrypt(input logic [127:0] k, input logic [127:0] n,
                                      input logic [63:0] ad);
        int nfull;
        logic [63:0] p, c;
        ms[0] = 64'h80400c0600000000; ms[1] = k[127:64]; ms[2] = k[63:0];
        ms[3] = n[127:64];            ms[4] = n[63:0];
        m_perm(12);
        ms[3] = ms[3] ^ k[127:64]; ms[4] = ms[4] ^ k[63:0];
        ms[0] = ms[0] ^ ad;
        m_perm(6);
        ms[4] = ms[4] ^ 64'd1;
        ct.delete(); exp_pt.delete();
        nfull  = msg.size() / 8;
        last_n = msg.size() % 8;
        for (int i = 0; i < nfull; i++) begin
            for (int j = 0; j < 8; j++) p[63 - 8*j -: 8] = msg[8*i + j];
            c = p ^ ms[0];
            ct.push_back(c); exp_pt.push_back(p);
            ms[0] = c;
            m_perm(6);
        end
        p = '0;
        for (int j = 0; j < last_n; j++) p[63 - 8*j -: 8] = msg[8*nfull + j];
        exp_pt.push_back(p);
        c = p ^ ms[0];
        for (int j = last_n; j < 8; j++) c[63 - 8*j -: 8] = 8'($urandom);
        ct.push_back(c);
        p[63 - 8*last_n -: 8] = 8'h80;
        ms[0] = ms[0] ^ p;
        ms[1] = ms[1] ^ k[127:64]; ms[2] = ms[2] ^ k[63:0];
        m_perm(12);
        exp_tag = {ms[3] ^ k[127:64], ms[4] ^ k[63:0]};
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic run_dec(input logic [127:0] k, input logic [127:0] nn,
                           input logic [63:0] ad, input logic [127:0] tg,
                           input bit hold, input bit poke, input bit exp_ok,
                           input int abort_at);
        int cyc, idx, pv_idx, flag_cyc, ready_cyc, done_cyc, gap, nblk;
        bit pend, got_done, aborted;
        logic [319:0] ld;
        nblk = ct.size();
        @(negedge clk);
        key_i = k; nonce_i = nn; ad_i = ad; tag_i = tg; start_i = 1'b1;
        cipher_valid_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        nonce_i = {$urandom, $urandom, $urandom, $urandom};
        ad_i    = {$urandom, $urandom};
        ld = dut.r_s;
        chk("load_state", ld, {64'h80400c0600000000, k, nn});
        chk("tag_ok_cleared_on_start", tag_ok_o, 1'b0);
        cyc = 1; idx = 0; pv_idx = 0; flag_cyc = -1; ready_cyc = -1; done_cyc = -1;
        gap = hold ? 0 : int'($urandom_range(0, 3));
        pend = 0; got_done = 0; aborted = 0;
        while (!got_done && !aborted && cyc < 3000) begin
            if (ready_cyc < 0 && cipher_ready_o) ready_cyc = cyc;
            if (plain_valid_o) begin
                if (pv_idx < nblk) chk("plain", plain_o, exp_pt[pv_idx]);
                else chk("extra_plain_valid", plain_valid_o, 1'b0);
                pv_idx++;
            end
            if (done_o) begin
                got_done = 1; done_cyc = cyc;
            end else if (abort_at >= 0 && flag_cyc >= 0 && cyc == flag_cyc + abort_at) begin
                reset_i = 1'b1;
                #1;
                chk("reset_mid_final_outputs",
                    {busy_o, cipher_ready_o, done_o, tag_ok_o, plain_valid_o, plain_o}, '0);
                @(negedge clk);
                reset_i = 1'b0;
                aborted = 1;
            end
            if (!got_done && !aborted) begin
                if (pend) begin
                    pend = 0; idx++;
                    gap = hold ? 0 : int'($urandom_range(0, 3));
                end
                if (idx < nblk && gap == 0) begin
                    cipher_valid_i  = 1'b1;
                    cipher_i        = ct[idx];
                    cipher_last_i   = (idx == nblk - 1);
                    cipher_nbytes_i = cipher_last_i ? 3'(last_n) : 3'($urandom);
                end else begin
                    cipher_valid_i  = 1'b0;
                    cipher_i        = {$urandom, $urandom};
                    cipher_last_i   = 1'($urandom);
                    cipher_nbytes_i = 3'($urandom);
                    if (gap > 0) gap--;
                end
                if (cipher_ready_o && cipher_valid_i) begin
                    pend = 1;
                    if (idx == nblk - 1) flag_cyc = cyc;
                end
                if (poke && cyc == 30) begin
                    chk("busy_at_poke", busy_o, 1'b1);
                    start_i = 1'b1;
                    nonce_i = {$urandom, $urandom, $urandom, $urandom};
                end
                if (poke && cyc == 31) start_i = 1'b0;
                @(negedge clk);
                cyc++;
            end
        end
        cipher_valid_i = 1'b0;
        start_i = 1'b0;
        if (!aborted) begin
            chk("done_seen", got_done, 1'b1);
            chk("ready_latency", ready_cyc, 19);
            if (got_done) begin
                chk("tag_ok", tag_ok_o, exp_ok);
                chk("plain_count", pv_idx, nblk);
                chk("accept_to_done", done_cyc - flag_cyc - 1, 13);
                @(negedge clk);
                chk("done_pulse_status", {done_o, busy_o, tag_ok_o}, {2'b00, exp_ok});
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        logic [127:0] key, nn;
        logic [63:0]  ad, tmp;
        int           len;
        reset_i = 1'b1; start_i = 1'b0; key_i = '0; nonce_i = '0; tag_i = '0;
        ad_i = '0; cipher_i = '0; cipher_valid_i = 1'b0; cipher_last_i = 1'b0;
        cipher_nbytes_i = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {busy_o, cipher_ready_o, done_o, tag_ok_o, plain_valid_o, plain_o}, '0);
        reset_i = 1'b0;

        // Round trip: 23-byte message, 2 full blocks + last n=7.
        key = 128'h000102030405060708090a0b0c0d0e0f;
        nn  = 128'h000102030405060708090a0b0c0d0e0f;
        ad  = 64'h4153434f4e800000;
        msg.delete();
        for (int i = 0; i < 23; i++) msg.push_back(8'(8'h41 + i));
        m_encrypt(key, nn, ad);
        run_dec(key, nn, ad, exp_tag, 1'b0, 1'b0, 1'b1, -1);

        // Tampered tag.
        run_dec(key, nn, ad, exp_tag ^ 128'd1, 1'b0, 1'b0, 1'b0, -1);

        // Tampered ciphertext: flip the top bit of the last block; the first
        // plaintext byte of that block flips with it.
        tmp = ct[ct.size() - 1];     tmp[63] = ~tmp[63]; ct[ct.size() - 1] = tmp;
        tmp = exp_pt[ct.size() - 1]; tmp[63] = ~tmp[63]; exp_pt[ct.size() - 1] = tmp;
        run_dec(key, nn, ad, exp_tag, 1'b0, 1'b0, 1'b0, -1);

        // Aligned 16-byte message, valid held high, start poked while busy.
        key = {$urandom, $urandom, $urandom, $urandom};
        nn  = {$urandom, $urandom, $urandom, $urandom};
        ad  = {$urandom, $urandom};
        msg.delete();
        for (int i = 0; i < 16; i++) msg.push_back(8'($urandom));
        m_encrypt(key, nn, ad);
        run_dec(key, nn, ad, exp_tag, 1'b1, 1'b1, 1'b1, -1);

        // Reset during FINAL, then a fresh message.
        msg.delete();
        for (int i = 0; i < 10; i++) msg.push_back(8'($urandom));
        m_encrypt(key, nn, ad);
        run_dec(key, nn, ad, exp_tag, 1'b0, 1'b0, 1'b1, 5);
        run_dec(key, nn, ad, exp_tag, 1'b0, 1'b0, 1'b1, -1);

        // Randomized messages.
        for (int t = 0; t < 6; t++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            nn  = {$urandom, $urandom, $urandom, $urandom};
            ad  = {$urandom, $urandom};
            len = int'($urandom_range(0, 40));
            msg.delete();
            for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
            m_encrypt(key, nn, ad);
            run_dec(key, nn, ad, exp_tag, 1'($urandom), 1'b0, 1'b1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
